// File: rtl/lut_or_tb_pkg.sv
// Shared types and constants for the lut_or stimulus/response checker.
// Includes the Galois LFSR step used to generate operand vectors.
package lut_or_tb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_e;

    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam int          DIRECTED_A  = 3;
    localparam int          DIRECTED_B  = 8;
    localparam int          MAX_LATENCY = 4;

    // Right-shifting Galois form: the feedback bit folds the tap mask into the shifted state.
    function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/lut_or_lfsr.sv
// 32-bit Galois LFSR; exposes the operand fields of its next state so the
// caller can register them in the same cycle the LFSR steps.
module lut_or_lfsr
    import lut_or_tb_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [31:0] SEED  = 32'h1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_next_a,
    output logic [WIDTH-1:0] o_next_b
);

    logic [31:0] r_state;
    logic [31:0] w_next;

    assign w_next = lfsr_advance(r_state);

    always_ff @(posedge clock) begin
        if (reset || i_load) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

    assign o_next_a = w_next[WIDTH-1:0];
    assign o_next_b = w_next[16+WIDTH-1:16];

endmodule

// File: rtl/lut_or_stim_check.sv
// Drives operand pairs into a LUT OR kernel and checks y against a|b after
// LATENCY cycles; reports pass, a saturating mismatch count and the first failure.
module lut_or_stim_check
    import lut_or_tb_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          LATENCY     = 0,
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      fail_count,
    output logic [15:0]      first_fail_step,
    output logic [WIDTH-1:0] first_fail_y
);

    localparam logic [15:0]      LAST_STEP  = 16'(NUM_VECTORS - 1);
    localparam logic [2:0]       DRAIN_LAST = 3'(LATENCY - 1);
    localparam logic [WIDTH-1:0] DIR_A      = WIDTH'(DIRECTED_A);
    localparam logic [WIDTH-1:0] DIR_B      = WIDTH'(DIRECTED_B);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [15:0]      r_step;
    logic [2:0]       r_drain;
    logic [15:0]      r_fail_count;
    logic [15:0]      r_ff_step;
    logic [WIDTH-1:0] r_ff_y;

    logic             w_start_ok;
    logic             w_lfsr_step;
    logic [WIDTH-1:0] w_next_a;
    logic [WIDTH-1:0] w_next_b;
    logic             w_v0;
    logic [WIDTH-1:0] w_e0;
    logic [15:0]      w_s0;
    logic             w_cv;
    logic [WIDTH-1:0] w_ce;
    logic [15:0]      w_cs;
    logic             w_mismatch;

    assign w_start_ok  = start && (r_state == IDLE || r_state == DONE);
    assign w_lfsr_step = (r_state == RUN) && (r_step != LAST_STEP);

    lut_or_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_start_ok),
        .i_step   (w_lfsr_step),
        .o_next_a (w_next_a),
        .o_next_b (w_next_b)
    );

    // Stage 0 of the expected pipe is the vector currently on a/b.
    assign w_v0 = (r_state == RUN);
    assign w_e0 = r_a | r_b;
    assign w_s0 = r_step;

    generate
        if (LATENCY == 0) begin : g_comb
            assign w_cv = w_v0;
            assign w_ce = w_e0;
            assign w_cs = w_s0;
        end else begin : g_pipe
            logic             r_pv [LATENCY];
            logic [WIDTH-1:0] r_pe [LATENCY];
            logic [15:0]      r_ps [LATENCY];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int unsigned i = 0; i < LATENCY; i++) begin
                        r_pv[i] <= 1'b0;
                        r_pe[i] <= '0;
                        r_ps[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= w_v0;
                    r_pe[0] <= w_e0;
                    r_ps[0] <= w_s0;
                    for (int unsigned i = 1; i < LATENCY; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pe[i] <= r_pe[i-1];
                        r_ps[i] <= r_ps[i-1];
                    end
                end
            end

            assign w_cv = r_pv[LATENCY-1];
            assign w_ce = r_pe[LATENCY-1];
            assign w_cs = r_ps[LATENCY-1];
        end
    endgenerate

    assign w_mismatch = w_cv && (y != w_ce);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_a          <= DIR_A;
            r_b          <= DIR_B;
            r_step       <= '0;
            r_drain      <= '0;
            r_fail_count <= '0;
            r_ff_step    <= '0;
            r_ff_y       <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state      <= RUN;
                        r_a          <= DIR_A;
                        r_b          <= DIR_B;
                        r_step       <= '0;
                        r_fail_count <= '0;
                        r_ff_step    <= '0;
                        r_ff_y       <= '0;
                    end
                end
                RUN: begin
                    if (r_step == LAST_STEP) begin
                        r_state <= (LATENCY == 0) ? DONE : DRAIN;
                        r_drain <= '0;
                    end else begin
                        r_step <= r_step + 16'd1;
                        r_a    <= w_next_a;
                        r_b    <= w_next_b;
                    end
                end
                DRAIN: begin
                    r_drain <= r_drain + 3'd1;
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Compares are only valid in RUN/DRAIN, so they never collide with the clear on start.
            if (w_mismatch) begin
                if (r_fail_count != 16'hFFFF) begin
                    r_fail_count <= r_fail_count + 16'd1;
                end
                if (r_fail_count == 16'd0) begin
                    r_ff_step <= w_cs;
                    r_ff_y    <= y;
                end
            end
        end
    end

    assign a               = r_a;
    assign b               = r_b;
    assign busy            = (r_state == RUN) || (r_state == DRAIN);
    assign done            = (r_state == DONE);
    assign pass            = done && (r_fail_count == 16'd0);
    assign fail_count      = r_fail_count;
    assign first_fail_step = r_ff_step;
    assign first_fail_y    = r_ff_y;

endmodule
